// File: rtl/img_loader_pkg.sv
// Shared definitions for the UART-to-framebuffer image loader: FSM states,
// sync bytes and error codes.
package img_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC2,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_CHECK
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle watchdog: counts enabled, uncleared cycles and flags the
// cycle in which the count sits at TIMEOUT_CYCLES-1.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_enable) begin
      cnt_d = '0;
    end else if (cnt_q != LAST_CNT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A clear in the expiry cycle means a strobe arrived, which takes priority.
  assign o_expire = i_enable && !i_clear && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/img_stream_loader.sv
// Parses A5 5A <pixel pairs> <checksum> packets from the UART byte stream and
// writes RGB444 pixels into the frame buffer, reporting completion or error.
module img_stream_loader
  import img_loader_pkg::*;
#(
  parameter int unsigned NUM_PIXELS     = 12288,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [11:0]           o_wr_data,
  output logic                  o_frame_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic                  o_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            sum_q, sum_d;
  logic [3:0]            r_q, r_d;
  err_code_t             err_code_q, err_code_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]           wr_data_q, wr_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic to_clear;
  logic to_enable;
  logic to_expire;

  assign to_enable = (state_q != ST_IDLE);
  assign to_clear  = i_rx_done || (state_q == ST_IDLE);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk     (i_clk_sys),
    .rst     (i_rst),
    .i_clear (to_clear),
    .i_enable(to_enable),
    .o_expire(to_expire)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sum_d        = sum_q;
    r_d          = r_q;
    err_code_d   = err_code_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    if (i_rx_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_rx_data == SYNC0) state_d = ST_SYNC2;
        end
        ST_SYNC2: begin
          if (i_rx_data == SYNC1) begin
            state_d    = ST_PIX_HI;
            addr_d     = '0;
            sum_d      = '0;
            err_code_d = ERR_NONE;
          end else if (i_rx_data != SYNC0) begin
            state_d = ST_IDLE;
          end
        end
        ST_PIX_HI: begin
          r_d     = i_rx_data[3:0];
          sum_d   = sum_q + i_rx_data;
          state_d = ST_PIX_LO;
        end
        ST_PIX_LO: begin
          sum_d     = sum_q + i_rx_data;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {r_q, i_rx_data};
          if (addr_q == LAST_ADDR) begin
            state_d = ST_CHECK;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_PIX_HI;
          end
        end
        ST_CHECK: begin
          if (i_rx_data == sum_q) begin
            frame_done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_expire) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end

    // Registered from the next state so busy drops together with done/err.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sum_q        <= '0;
      r_q          <= '0;
      err_code_q   <= ERR_NONE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      r_q          <= r_d;
      err_code_q   <= err_code_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed/randomized bench for img_stream_loader with a small 4-pixel frame;
// expected writes and checksums come from the packet rules applied to the payload.
module tb_img_stream_loader;

  localparam int NP = 4;
  localparam int AW = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_done = 1'b0;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [11:0]   o_wr_data;
  logic          o_frame_done;
  logic          o_err;
  logic [1:0]    o_err_code;
  logic          o_busy;

  always #5 clk = ~clk;

  img_stream_loader #(
    .NUM_PIXELS    (NP),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk_sys   (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_frame_done(o_frame_done),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int mon_wa[$];
  int mon_wd[$];
  int mon_wc[$];
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (o_wr_en) begin
      mon_wa.push_back(int'(o_wr_addr));
      mon_wd.push_back(int'(o_wr_data));
      mon_wc.push_back(cyc);
    end
    if (o_frame_done) done_cnt++;
    if (o_err) err_cnt++;
  end

  logic [7:0] pix [2*NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_wa.delete();
    mon_wd.delete();
    mon_wc.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 2*NP; i++) pix[i] = 8'($urandom);
  endtask

  function automatic logic [7:0] csum();
    int s = 0;
    for (int i = 0; i < 2*NP; i++) s += int'(pix[i]);
    return 8'(s % 256);
  endfunction

  // Drives a one-cycle strobe starting at the current negedge.
  task automatic send_now(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] ck, input bit b2b);
    logic [7:0] bytes [$];
    bytes.push_back(8'hA5);
    bytes.push_back(8'h5A);
    for (int i = 0; i < 2*NP; i++) bytes.push_back(pix[i]);
    bytes.push_back(ck);
    foreach (bytes[i]) begin
      send_now(bytes[i]);
      if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    logic [11:0] exp_px;
    chk({tag, "_wr_count"}, mon_wa.size(), NP);
    for (int i = 0; i < NP && i < mon_wa.size(); i++) begin
      exp_px = {pix[2*i][3:0], pix[2*i+1]};
      chk($sformatf("%s_wr_addr%0d", tag, i), mon_wa[i], i);
      chk($sformatf("%s_wr_data%0d", tag, i), mon_wd[i], exp_px);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},      o_wr_en, 0);
    chk({tag, "_wr_addr"},    o_wr_addr, 0);
    chk({tag, "_wr_data"},    o_wr_data, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_err"},        o_err, 0);
    chk({tag, "_err_code"},   o_err_code, 0);
    chk({tag, "_busy"},       o_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Good frame with the reference payload.
    pix[0] = 8'h0F; pix[1] = 8'hFF; pix[2] = 8'h01; pix[3] = 8'h23;
    pix[4] = 8'h0A; pix[5] = 8'hBC; pix[6] = 8'h00; pix[7] = 8'h00;
    clear_mon();
    send_frame(csum(), 1'b0);
    settle();
    check_writes("good");
    chk("good_done", done_cnt, 1);
    chk("good_err", err_cnt, 0);
    chk("good_code", o_err_code, 2'b00);
    chk("good_busy", o_busy, 0);

    // Bad checksum.
    rand_payload();
    clear_mon();
    send_frame(csum() + 8'd1, 1'b0);
    settle();
    check_writes("badck");
    chk("badck_err", err_cnt, 1);
    chk("badck_code", o_err_code, 2'b01);
    chk("badck_done", done_cnt, 0);

    // Timeout after the first pixel byte: fires TO idle cycles after the last strobe.
    clear_mon();
    send_now(8'hA5);
    send_now(8'h5A);
    send_now(8'h0F);
    repeat (TO - 1) @(negedge clk);
    chk("to_early_err", err_cnt, 0);
    chk("to_early_busy", o_busy, 1);
    @(negedge clk);
    chk("to_err_pulse", o_err, 1);
    chk("to_busy", o_busy, 0);
    @(negedge clk);
    chk("to_err_one_cycle", o_err, 0);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_code", o_err_code, 2'b10);
    chk("to_writes", mon_wa.size(), 0);

    rand_payload();
    clear_mon();
    send_frame(csum(), 1'b0);
    settle();
    check_writes("after_to");
    chk("after_to_done", done_cnt, 1);
    chk("after_to_code", o_err_code, 2'b00);

    // Sync hunting: 00 A5 A5 5A locks on the second A5.
    rand_payload();
    clear_mon();
    send_now(8'h00);
    send_now(8'hA5);
    send_frame(csum(), 1'b0);
    settle();
    check_writes("hunt");
    chk("hunt_done", done_cnt, 1);

    clear_mon();
    send_now(8'h00);
    send_now(8'hA5);
    chk("hunt_sync_busy", o_busy, 1);
    send_now(8'h33);
    chk("hunt_abort_busy", o_busy, 0);
    settle();
    chk("hunt_abort_err", err_cnt, 0);
    chk("hunt_abort_code", o_err_code, 2'b00);
    chk("hunt_abort_writes", mon_wa.size(), 0);

    // Reset after the third pixel byte.
    rand_payload();
    pix[1] = 8'h5C;
    clear_mon();
    send_now(8'hA5);
    send_now(8'h5A);
    send_now(pix[0]);
    send_now(pix[1]);
    send_now(pix[2]);
    chk("rst_pre_busy", o_busy, 1);
    chk("rst_pre_data", o_wr_data, {pix[0][3:0], pix[1]});
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rx_data = 8'hA5;
    rx_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_done = 1'b0;
    send_now(8'h5A);
    chk("rst_strobe_ignored", o_busy, 0);
    rand_payload();
    clear_mon();
    send_frame(csum(), 1'b0);
    settle();
    check_writes("post_rst");
    chk("post_rst_done", done_cnt, 1);

    // Back-to-back strobes.
    rand_payload();
    clear_mon();
    send_frame(csum(), 1'b1);
    settle();
    check_writes("b2b");
    chk("b2b_done", done_cnt, 1);
    chk("b2b_err", err_cnt, 0);
    for (int i = 1; i < mon_wc.size(); i++)
      chk($sformatf("b2b_spacing%0d", i), mon_wc[i] - mon_wc[i-1], 2);

    // Strobe landing on the expiry cycle is accepted.
    rand_payload();
    clear_mon();
    send_now(8'hA5);
    send_now(8'h5A);
    repeat (TO - 1) @(negedge clk);
    for (int i = 0; i < 2*NP; i++) send_now(pix[i]);
    send_now(csum());
    settle();
    check_writes("edge");
    chk("edge_err", err_cnt, 0);
    chk("edge_done", done_cnt, 1);
    chk("edge_code", o_err_code, 2'b00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
